// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: issues word fetches and buffers halfwords.
// It assembles RVC and 32-bit instructions for decode and flushes on redirect.
module fetch_seq #(
  parameter logic [63:0] RESET_PC = 64'h1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        inst_compressed,
  output logic [63:0] inst_pc
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] hbuf_q [3];
  logic [15:0] hbuf_d [3];
  logic [1:0]  hcnt_q, hcnt_d;
  logic [63:0] fetch_addr_q, fetch_addr_d;
  logic [63:0] pend_addr_q, pend_addr_d;
  logic [63:0] cur_pc_q, cur_pc_d;
  logic        skip_q, skip_d;
  logic        discard_q, discard_d;
  logic        compressed_s;
  logic        consume_s;
  logic [63:0] target_pc_s;

  assign compressed_s    = (hbuf_q[0][1:0] != 2'b11);
  assign inst_valid      = ((hcnt_q >= 2'd1) && compressed_s) || (hcnt_q >= 2'd2);
  assign inst            = compressed_s ? {16'h0000, hbuf_q[0]} : {hbuf_q[1], hbuf_q[0]};
  assign inst_compressed = compressed_s;
  assign inst_pc         = cur_pc_q;
  assign mem_req_valid   = (state_q == REQ);
  assign mem_req_addr    = fetch_addr_q;
  assign consume_s       = inst_valid & ~stall;
  assign target_pc_s     = {redirect_pc[63:1], 1'b0};

  // Next-state: consume shift, response append, fetch FSM, then redirect override.
  always_comb begin
    state_d      = state_q;
    hbuf_d       = hbuf_q;
    hcnt_d       = hcnt_q;
    fetch_addr_d = fetch_addr_q;
    pend_addr_d  = pend_addr_q;
    cur_pc_d     = cur_pc_q;
    skip_d       = skip_q;
    discard_d    = discard_q;

    if (consume_s) begin
      if (compressed_s) begin
        hbuf_d[0] = hbuf_q[1];
        hbuf_d[1] = hbuf_q[2];
        hcnt_d    = hcnt_q - 2'd1;
        cur_pc_d  = cur_pc_q + 64'd2;
      end else begin
        hbuf_d[0] = hbuf_q[2];
        hcnt_d    = hcnt_q - 2'd2;
        cur_pc_d  = cur_pc_q + 64'd4;
      end
    end else begin
      hcnt_d = hcnt_q;
    end

    // Append lands on top of whatever the shift left behind.
    if ((state_q == WAIT) && mem_resp_valid && !discard_q) begin
      if (skip_q) begin
        for (int i = 0; i < 3; i++) begin
          if (2'(i) == hcnt_d) hbuf_d[i] = mem_resp_data[31:16];
          else hbuf_d[i] = hbuf_d[i];
        end
        hcnt_d = hcnt_d + 2'd1;
        skip_d = 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (2'(i) == hcnt_d) hbuf_d[i] = mem_resp_data[15:0];
          else if (2'(i) == hcnt_d + 2'd1) hbuf_d[i] = mem_resp_data[31:16];
          else hbuf_d[i] = hbuf_d[i];
        end
        hcnt_d = hcnt_d + 2'd2;
      end
    end else begin
      skip_d = skip_q;
    end

    case (state_q)
      IDLE: begin
        if ((hcnt_q <= 2'd1) && !redirect_en) state_d = REQ;
        else state_d = IDLE;
      end
      REQ: begin
        if (mem_req_ready) begin
          fetch_addr_d = fetch_addr_q + 64'd4;
          state_d      = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
          if (discard_q) begin
            discard_d    = 1'b0;
            fetch_addr_d = pend_addr_q;
          end else begin
            discard_d = 1'b0;
          end
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect with a request in flight parks the target until the drop completes.
    if (redirect_en) begin
      hcnt_d   = 2'd0;
      cur_pc_d = target_pc_s;
      skip_d   = redirect_pc[1];
      case (state_q)
        IDLE: fetch_addr_d = {redirect_pc[63:2], 2'b00};
        REQ: begin
          discard_d   = 1'b1;
          pend_addr_d = {redirect_pc[63:2], 2'b00};
        end
        WAIT: begin
          if (mem_resp_valid) begin
            discard_d    = 1'b0;
            fetch_addr_d = {redirect_pc[63:2], 2'b00};
          end else begin
            discard_d   = 1'b1;
            pend_addr_d = {redirect_pc[63:2], 2'b00};
          end
        end
        default: fetch_addr_d = {redirect_pc[63:2], 2'b00};
      endcase
    end else begin
      pend_addr_d = pend_addr_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hbuf_q       <= '{default: 16'h0000};
      hcnt_q       <= 2'd0;
      fetch_addr_q <= {RESET_PC[63:2], 2'b00};
      pend_addr_q  <= 64'd0;
      cur_pc_q     <= RESET_PC;
      skip_q       <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hbuf_q       <= hbuf_d;
      hcnt_q       <= hcnt_d;
      fetch_addr_q <= fetch_addr_d;
      pend_addr_q  <= pend_addr_d;
      cur_pc_q     <= cur_pc_d;
      skip_q       <= skip_d;
      discard_q    <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed scenarios plus randomized traffic, all
// checked against a PC-driven instruction-stream model over a memory image.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_en = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        stall = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_compressed;
  logic [63:0] inst_pc;

  always #5 clk = ~clk;

  fetch_seq #(.RESET_PC(64'h1000)) dut (
    .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .stall(stall), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .inst_valid(inst_valid), .inst(inst),
    .inst_compressed(inst_compressed), .inst_pc(inst_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory image: explicit words override a hashed background.
  logic [31:0] mem_init [logic [63:0]];

  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [63:0] wa;
    logic [31:0] x;
    wa = {a[63:2], 2'b00};
    if (mem_init.exists(wa)) return mem_init[wa];
    x = wa[31:0] ^ wa[63:32] ^ 32'h5a5a1234;
    x = x * 32'h9E3779B1;
    x = x ^ (x >> 13);
    return x;
  endfunction

  function automatic logic [15:0] half_at(input logic [63:0] a);
    logic [31:0] w;
    w = word_at(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  logic [63:0] m_pc = 64'h1000;
  logic [63:0] resp_q [$];
  logic [63:0] req_log [$];
  logic [63:0] cons_pc [$];
  logic [31:0] cons_inst [$];
  logic        rand_mode = 1'b0;
  logic        hold_resp = 1'b0;
  logic        ready_force = 1'b1;
  logic        req_hold = 1'b0;
  logic [63:0] held_addr = 64'd0;
  int          starve = 0;

  // One clock cycle: drive inputs, play memory, score the stream, then advance.
  task automatic step(input logic r, input logic re, input logic [63:0] rpc, input logic st);
    logic        rdy;
    logic [15:0] h0;
    logic [31:0] exp_inst;
    logic        exp_c;
    rdy = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    rst = r; redirect_en = re & ~r; redirect_pc = rpc; stall = st; mem_req_ready = rdy;
    mem_resp_valid = 1'b0; mem_resp_data = 32'd0;
    if (r) begin
      resp_q.delete();
      m_pc = 64'h1000; req_hold = 1'b0; starve = 0;
    end else begin
      if (!hold_resp && resp_q.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = word_at(resp_q.pop_front());
      end
      if (req_hold) begin
        check("req_valid_held", mem_req_valid, 1'b1);
        check("req_addr_held", mem_req_addr, held_addr);
      end
      if (mem_req_valid) begin
        check("req_align", mem_req_addr[1:0], 2'b00);
        check("single_outstanding", resp_q.size(), 0);
        if (rdy) begin
          resp_q.push_back(mem_req_addr);
          req_log.push_back(mem_req_addr);
        end
      end
      req_hold  = mem_req_valid && !rdy;
      held_addr = mem_req_addr;
      if (re) begin
        m_pc = {rpc[63:1], 1'b0};
      end else if (inst_valid && !st) begin
        h0 = half_at(m_pc);
        exp_c = (h0[1:0] != 2'b11);
        exp_inst = exp_c ? {16'h0000, h0} : {half_at(m_pc + 64'd2), h0};
        check("inst_pc", inst_pc, m_pc);
        check("inst", inst, exp_inst);
        check("inst_compressed", inst_compressed, exp_c);
        cons_pc.push_back(inst_pc);
        cons_inst.push_back(inst);
        m_pc = m_pc + (exp_c ? 64'd2 : 64'd4);
      end
      if (inst_valid || re) starve = 0;
      else starve++;
      if (starve > 60) begin
        check("starve_timeout", starve, 0);
        starve = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Run unstalled cycles until the request log (which=0) or consume log reaches target.
  task automatic run_until(input int which, input int target, input string tag);
    int cnt;
    cnt = (which == 0) ? req_log.size() : cons_pc.size();
    for (int i = 0; i < 60 && cnt < target; i++) begin
      step(1'b0, 1'b0, 64'd0, 1'b0);
      cnt = (which == 0) ? req_log.size() : cons_pc.size();
    end
    check(tag, cnt >= target, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b0);
  endtask

  initial begin
    int r0, c0;
    logic [31:0] s_inst;
    logic [63:0] s_pc;
    logic found;

    mem_init[64'h1000] = 32'h00000013;
    mem_init[64'h1004] = 32'h00100093;
    do_reset();
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_pc", inst_pc, 64'h1000);
    check("rst_req_addr", mem_req_addr, 64'h1000);
    req_log.delete(); cons_pc.delete(); cons_inst.delete();
    run_until(1, 2, "t1_consumed");
    check("t1_req0", req_log[0], 64'h1000);
    check("t1_pc0", cons_pc[0], 64'h1000);
    check("t1_inst0", cons_inst[0], 32'h00000013);
    check("t1_pc1", cons_pc[1], 64'h1004);
    check("t1_inst1", cons_inst[1], 32'h00100093);

    mem_init[64'h1000] = 32'h00934501;
    mem_init[64'h1004] = 32'h00000010;
    do_reset();
    req_log.delete(); cons_pc.delete(); cons_inst.delete();
    run_until(1, 2, "t2_consumed");
    check("t2_pc0", cons_pc[0], 64'h1000);
    check("t2_inst0", cons_inst[0], 32'h00004501);
    check("t2_pc1", cons_pc[1], 64'h1002);
    check("t2_inst1", cons_inst[1], 32'h00100093);

    mem_init[64'h2000] = 32'h45011234;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 64'd0, 1'b1);
    r0 = req_log.size();
    step(1'b0, 1'b1, 64'h2002, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    check("t3_not_yet", inst_valid, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    check("t3_latency3", inst_valid, 1'b1);
    check("t3_pc", inst_pc, 64'h2002);
    check("t3_inst", inst, 32'h00004501);
    check("t3_req", req_log[r0], 64'h2000);

    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, 1'b0, 64'd0, 1'b0);
      if (req_log.size() > 0 && req_log[req_log.size() - 1] == 64'h1008) found = 1'b1;
    end
    check("t4_reached_1008", found, 1'b1);
    hold_resp = 1'b1;
    r0 = req_log.size(); c0 = cons_pc.size();
    step(1'b0, 1'b1, 64'h3000, 1'b0);
    hold_resp = 1'b0;
    run_until(1, c0 + 1, "t4_consumed");
    check("t4_next_req", req_log[r0], 64'h3000);
    check("t4_first_pc", cons_pc[c0], 64'h3000);

    for (int i = 0; i < 20 && !inst_valid; i++) step(1'b0, 1'b0, 64'd0, 1'b1);
    s_inst = inst; s_pc = inst_pc; r0 = req_log.size();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 64'd0, 1'b1);
      check("t5_valid", inst_valid, 1'b1);
      check("t5_inst_stable", inst, s_inst);
      check("t5_pc_stable", inst_pc, s_pc);
    end
    check("t5_extra_reqs_le1", (req_log.size() - r0) <= 1, 1'b1);
    c0 = cons_pc.size();
    run_until(1, c0 + 4, "t5_resume");
    check("t5_resume_pc", cons_pc[c0], s_pc);

    do_reset();
    r0 = req_log.size(); c0 = cons_pc.size();
    ready_force = 1'b0;
    step(1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, (i == 2), 64'h4000, 1'b0);
      check("t6_req_valid", mem_req_valid, 1'b1);
      check("t6_req_addr", mem_req_addr, 64'h1000);
    end
    ready_force = 1'b1;
    run_until(1, c0 + 1, "t6_consumed");
    check("t6_req0", req_log[r0], 64'h1000);
    check("t6_req1", req_log[r0 + 1], 64'h4000);
    check("t6_first_pc", cons_pc[c0], 64'h4000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      r0 = req_log.size();
      step(1'b0, 1'b0, 64'd0, 1'b1);
      if (req_log.size() > r0) found = 1'b1;
    end
    check("t6_in_wait", found, 1'b1);
    hold_resp = 1'b1;
    step(1'b1, 1'b0, 64'd0, 1'b0);
    hold_resp = 1'b0;
    check("t6_rst_req_valid", mem_req_valid, 1'b0);
    check("t6_rst_inst_valid", inst_valid, 1'b0);
    check("t6_rst_inst_pc", inst_pc, 64'h1000);
    check("t6_rst_req_addr", mem_req_addr, 64'h1000);
    r0 = req_log.size();
    run_until(0, r0 + 1, "t6_req_after_rst");
    check("t6_req_after_rst_addr", req_log[r0], 64'h1000);

    rand_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 29) == 0,
           64'h8000 + 64'($urandom_range(0, 8191)), $urandom_range(0, 3) == 0);
    end
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction-fetch sequencer in front of the PC datapath. It issues word-aligned 32-bit fetch requests to the instruction memory port and buffers the returned halfwords. From those halfwords it assembles 16-bit (RVC) and 32-bit instructions, which it presents to decode together with their PC. Trap and branch/jump redirects flush the buffer and discard any in-flight fetch, so decode sees only the instruction stream starting at the new PC.

Parameters:
RESET_PC, 64'h1000, PC of the first instruction fetched after reset.

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
redirect_en  in  1  trap or branch/jump redirect, merged upstream
redirect_pc  in  64  new PC; bit 0 is ignored and treated as 0
stall  in  1  decode backpressure; an instruction is consumed when inst_valid & ~stall
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts the request
mem_req_addr  out  64  fetch address; bits [1:0] always 0
mem_resp_valid  in  1  response valid; exactly one per accepted request, in order, at least 1 cycle after acceptance
mem_resp_data  in  32  response word; bits [15:0] are the halfword at the lower address
inst_valid  out  1  a complete instruction is available
inst  out  32  instruction; for RVC, {16'h0, halfword}
inst_compressed  out  1  inst[1:0] != 2'b11
inst_pc  out  64  PC of inst

Behaviour:
- State (all registered):
  - hbuf: 3 x 16-bit halfwords
  - hcnt: 0..3 valid halfwords
  - fetch_addr: next word to fetch
  - cur_pc
  - skip: drop the low halfword of the next accepted response
  - discard: drop the next response
  - FSM in {IDLE, REQ, WAIT}
- Reset (rst high at a clk edge) values:
  - FSM=IDLE, hcnt=0, skip=0, discard=0
  - fetch_addr=RESET_PC & ~3, cur_pc=RESET_PC
  - mem_req_valid=0, inst_valid=0
  - Reset mid-transaction abandons any outstanding response. The memory side is reset together with this block.
- Outputs are driven from registered state only. No combinational path from any input to any output.
  - inst_valid = (hcnt>=1 && hbuf[0][1:0]!=2'b11) || hcnt>=2
  - inst = compressed ? {16'h0,hbuf[0]} : {hbuf[1],hbuf[0]}
  - inst_pc = cur_pc
  - mem_req_valid = (FSM==REQ)
  - mem_req_addr = fetch_addr
- FSM:
  - IDLE: if hcnt<=1 and not redirect_en, go to REQ.
  - REQ: when mem_req_ready, fetch_addr += 4 (mod 2^64), go to WAIT. valid and addr are held stable until accepted, even across a redirect.
  - WAIT: on mem_resp_valid, go to IDLE.
- Response handling (in WAIT):
  - If discard: drop the response and clear discard.
  - Else if skip: append mem_resp_data[31:16] (hcnt+1) and clear skip.
  - Else: append both halfwords, low first (hcnt+2).
- Consume (inst_valid & ~stall):
  - Shift hbuf down by 1 (RVC) or 2 halfwords.
  - cur_pc += 2 or 4.
  - The same-cycle append lands after the shift.
  - Since requests are only issued at hcnt<=1, hcnt never exceeds 3 and there is no overflow.
- Redirect (redirect_en high at an edge): highest priority, overrides consume and append in that cycle.
  - hcnt=0, cur_pc=redirect_pc & ~1, skip=redirect_pc[1].
  - If FSM is in REQ or WAIT: discard=1 and FSM unchanged. The request still completes; its response is dropped. A response arriving in the same cycle as the redirect is dropped and leaves discard=0, FSM=IDLE.
    - If FSM is REQ, fetch_addr stays as issued, and the new target fetch starts after the drop. The new target is held in a pending-address register, loaded into fetch_addr when the dropped response returns.
  - If FSM is IDLE: fetch_addr=redirect_pc & ~3 immediately.
  - Back-to-back redirects: the last one wins, and at most one response is discarded per outstanding request.
- stall does not block fetching. Fetching stops on its own once hcnt reaches 2 or 3.
- A 32-bit instruction that straddles two words waits until both halves are buffered.
- Single outstanding request. Minimum latency from redirect to inst_valid, with ready=1 and a 1-cycle response: 3 cycles.

Test Plan:
1. Reset release, ready=1, 1-cycle response, memory @0x1000=0x00000013 and @0x1004=0x00100093 -> first request addr 0x1000. inst 0x00000013 at inst_pc 0x1000, then 0x00100093 at inst_pc 0x1004, each for exactly one consumed cycle.
2. Mixed RVC: word @0x1000=0x0093_4501 (c.li, then the low half of a 32-bit instruction), @0x1004=0x0000_0010 -> inst 0x00004501 compressed @0x1000, then inst 0x00100093 @0x1002 assembled across the two words.
3. Redirect to 0x2002 with FSM=IDLE -> next request addr 0x2000. The low halfword is dropped and the first inst_pc is 0x2002.
4. Redirect to 0x3000 while in WAIT for 0x1008 -> the 0x1008 response is dropped and never appears as inst. The next request is 0x3000 and the first inst_pc is 0x3000.
5. stall=1 held for 10 cycles with buffered data -> inst/inst_pc stable, at most 1 extra request issued, hcnt<=3. On release, the stream resumes with no gap or duplicate.
6. mem_req_ready=0 for 5 cycles plus a redirect during REQ -> addr stays stable until accepted. That response is discarded and the redirect target is fetched next. Then assert rst for one cycle mid-WAIT -> all outputs return to their reset values and the next request is 0x1000.
